// File: rtl/regfile_rename.sv
// Architectural register file with rename tags. Commits from the reorder buffer, renames from dispatch.
// Optional REGFILE_BYPASS_EN: same-cycle commit-to-read forwarding on both source ports.
module regfile_rename #(
   parameter int REG_NUM = 32,
   parameter int DATA_W  = 32,
   parameter int ROB_W   = 4,
   parameter int AW      = $clog2(REG_NUM)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clr,
   input  logic              Reg_write_S,
   input  logic [AW-1:0]     Reg_rd,
   input  logic [ROB_W-1:0]  Reg_Reorder,
   input  logic [DATA_W-1:0] Reg_result,
   input  logic              Dispatch_S,
   input  logic [AW-1:0]     Dispatch_rd,
   input  logic [ROB_W-1:0]  Dispatch_Reorder,
   input  logic [AW-1:0]     rs1_addr,
   output logic              rs1_busy,
   output logic [ROB_W-1:0]  rs1_reorder,
   output logic [DATA_W-1:0] rs1_value,
   input  logic [AW-1:0]     rs2_addr,
   output logic              rs2_busy,
   output logic [ROB_W-1:0]  rs2_reorder,
   output logic [DATA_W-1:0] rs2_value
);

   typedef struct packed {
      logic              busy;
      logic [ROB_W-1:0]  tag;
      logic [DATA_W-1:0] val;
   } rd_t;

   logic [DATA_W-1:0] value_q [REG_NUM];
   logic [DATA_W-1:0] value_d [REG_NUM];
   logic [ROB_W-1:0]  tag_q   [REG_NUM];
   logic [ROB_W-1:0]  tag_d   [REG_NUM];
   logic [REG_NUM-1:0] busy_q, busy_d;

   logic commit, rename;
   assign commit = rdy && Reg_write_S && (Reg_rd != '0);
   assign rename = rdy && Dispatch_S && !clr && (Dispatch_rd != '0);

   // A rename applied after the commit lets a same-cycle rename of the same rd win.
   always_comb begin
      value_d = value_q;
      tag_d   = tag_q;
      busy_d  = busy_q;
      if (commit) begin
         value_d[Reg_rd] = Reg_result;
         if (busy_q[Reg_rd] && (tag_q[Reg_rd] == Reg_Reorder))
            busy_d[Reg_rd] = 1'b0;
      end
      if (rdy && clr)
         busy_d = '0;
      else if (rename) begin
         busy_d[Dispatch_rd] = 1'b1;
         tag_d[Dispatch_rd]  = Dispatch_Reorder;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
         busy_q <= '0;
      end else begin
         value_q <= value_d;
         tag_q   <= tag_d;
         busy_q  <= busy_d;
      end
   end

   function automatic rd_t read_port(input logic [AW-1:0] a);
      rd_t r;
      logic hit;
      r = '0;
`ifdef REGFILE_BYPASS_EN
      hit = Reg_write_S && (Reg_rd == a) && busy_q[a] && (tag_q[a] == Reg_Reorder);
`else
      hit = 1'b0;
`endif
      if (rst && (a != '0)) begin
         if (hit)
            r.val = Reg_result;
         else if (busy_q[a]) begin
            r.busy = 1'b1;
            r.tag  = tag_q[a];
         end else
            r.val = value_q[a];
      end
      return r;
   endfunction

   rd_t rd1, rd2;
   always_comb rd1 = read_port(rs1_addr);
   always_comb rd2 = read_port(rs2_addr);

   assign rs1_busy    = rd1.busy;
   assign rs1_reorder = rd1.tag;
   assign rs1_value   = rd1.val;
   assign rs2_busy    = rd2.busy;
   assign rs2_reorder = rd2.tag;
   assign rs2_value   = rd2.val;

endmodule

// File: tb/tb_regfile_rename.sv
// Directed test-plan steps followed by random traffic checked against an array-based model.
module tb_regfile_rename;

   logic        clk = 1'b0;
   logic        rst, rdy, clr;
   logic        Reg_write_S;
   logic [4:0]  Reg_rd;
   logic [3:0]  Reg_Reorder;
   logic [31:0] Reg_result;
   logic        Dispatch_S;
   logic [4:0]  Dispatch_rd;
   logic [3:0]  Dispatch_Reorder;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        rs1_busy, rs2_busy;
   logic [3:0]  rs1_reorder, rs2_reorder;
   logic [31:0] rs1_value, rs2_value;

   int n_chk = 0;
   int n_err = 0;

   // Reference state: what the register file should hold, by register number.
   logic [31:0] m_val  [32];
   logic [3:0]  m_tag  [32];
   bit          m_busy [32];

   regfile_rename dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
      .Reg_write_S(Reg_write_S), .Reg_rd(Reg_rd), .Reg_Reorder(Reg_Reorder), .Reg_result(Reg_result),
      .Dispatch_S(Dispatch_S), .Dispatch_rd(Dispatch_rd), .Dispatch_Reorder(Dispatch_Reorder),
      .rs1_addr(rs1_addr), .rs1_busy(rs1_busy), .rs1_reorder(rs1_reorder), .rs1_value(rs1_value),
      .rs2_addr(rs2_addr), .rs2_busy(rs2_busy), .rs2_reorder(rs2_reorder), .rs2_value(rs2_value)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic chk1(input string name, input logic b, input logic [3:0] t, input logic [31:0] v);
      chk({name, ".busy"}, {31'd0, rs1_busy}, {31'd0, b});
      chk({name, ".reorder"}, {28'd0, rs1_reorder}, {28'd0, t});
      chk({name, ".value"}, rs1_value, v);
   endtask

   task automatic model_edge();
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_tag[i] = '0; m_busy[i] = 0;
         end
      end else if (rdy) begin
         if (Reg_write_S && Reg_rd != 0) begin
            m_val[Reg_rd] = Reg_result;
            if (m_busy[Reg_rd] && m_tag[Reg_rd] == Reg_Reorder) m_busy[Reg_rd] = 0;
         end
         if (clr) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
         end else if (Dispatch_S && Dispatch_rd != 0) begin
            m_busy[Dispatch_rd] = 1;
            m_tag[Dispatch_rd]  = Dispatch_Reorder;
         end
      end
   endtask

   task automatic model_read(input logic [4:0] a, output logic b, output logic [3:0] t,
                             output logic [31:0] v);
      b = 0; t = '0; v = '0;
      if (rst && a != 0) begin
         if (m_busy[a]) begin b = 1; t = m_tag[a]; end
         else v = m_val[a];
`ifdef REGFILE_BYPASS_EN
         if (Reg_write_S && Reg_rd == a && m_busy[a] && m_tag[a] == Reg_Reorder) begin
            b = 0; t = '0; v = Reg_result;
         end
`endif
      end
   endtask

   task automatic idle();
      clr = 0; Reg_write_S = 0; Reg_rd = '0; Reg_Reorder = '0; Reg_result = '0;
      Dispatch_S = 0; Dispatch_rd = '0; Dispatch_Reorder = '0;
   endtask

   // Clock edge: model consumes the inputs that the DUT sampled, then inputs may change.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic commit(input logic [4:0] rd, input logic [3:0] t, input logic [31:0] v);
      Reg_write_S = 1; Reg_rd = rd; Reg_Reorder = t; Reg_result = v;
   endtask

   task automatic rename(input logic [4:0] rd, input logic [3:0] t);
      Dispatch_S = 1; Dispatch_rd = rd; Dispatch_Reorder = t;
   endtask

   task automatic rd_at(input logic [4:0] a);
      idle(); rs1_addr = a; #1;
   endtask

   initial begin
      logic        eb;
      logic [3:0]  et;
      logic [31:0] ev;
      rst = 0; rdy = 1; idle(); rs1_addr = 5'd5; rs2_addr = 5'd0;
      #1;
      chk1("rst_x5", 0, 4'd0, 32'd0);
      tick(); tick();
      chk1("rst_hold", 0, 4'd0, 32'd0);
      rst = 1; #1;
      chk1("x5_after_rst", 0, 4'd0, 32'd0);

      commit(5'd0, 4'd0, 32'hDEAD); tick(); rd_at(5'd0);
      chk1("x0_ignored", 0, 4'd0, 32'd0);

      rename(5'd3, 4'd7); tick(); rd_at(5'd3);
      chk1("x3_renamed", 1, 4'd7, 32'd0);
      commit(5'd3, 4'd7, 32'h1234); tick(); rd_at(5'd3);
      chk1("x3_committed", 0, 4'd0, 32'h1234);

      rename(5'd3, 4'd2); tick(); idle();
      rename(5'd3, 4'd9); tick(); idle();
      commit(5'd3, 4'd2, 32'h55); tick(); rd_at(5'd3);
      chk1("x3_stale_commit", 1, 4'd9, 32'd0);
      commit(5'd3, 4'd9, 32'h66); tick(); rd_at(5'd3);
      chk1("x3_young_commit", 0, 4'd0, 32'h66);

      commit(5'd4, 4'd1, 32'hA); rename(5'd4, 4'd5); tick(); rd_at(5'd4);
      chk1("x4_rename_wins", 1, 4'd5, 32'd0);
      commit(5'd4, 4'd5, 32'hB); tick(); rd_at(5'd4);
      chk1("x4_final", 0, 4'd0, 32'hB);

      rename(5'd1, 4'd4); tick(); idle();
      rename(5'd2, 4'd6); tick(); idle();
      rename(5'd7, 4'd8); tick(); idle();
      clr = 1; commit(5'd1, 4'd4, 32'h80); rename(5'd9, 4'd10); tick();
      rd_at(5'd1); chk1("clr_x1", 0, 4'd0, 32'h80);
      rd_at(5'd2); chk1("clr_x2", 0, 4'd0, 32'd0);
      rd_at(5'd7); chk1("clr_x7", 0, 4'd0, 32'd0);
      rd_at(5'd9); chk1("clr_x9", 0, 4'd0, 32'd0);

      rdy = 0; rename(5'd5, 4'd3); commit(5'd4, 4'd0, 32'hFF); tick(); rdy = 1;
      rd_at(5'd5); chk1("rdy_low_x5", 0, 4'd0, 32'd0);
      rd_at(5'd4); chk1("rdy_low_x4", 0, 4'd0, 32'hB);

      rename(5'd6, 4'd3); tick(); idle();
      commit(5'd6, 4'd3, 32'h77); rs1_addr = 5'd6; #1;
`ifdef REGFILE_BYPASS_EN
      chk1("x6_bypass", 0, 4'd0, 32'h77);
`else
      chk1("x6_no_bypass", 1, 4'd3, 32'd0);
`endif
      tick(); rd_at(5'd6);
      chk1("x6_next", 0, 4'd0, 32'h77);

      // Random traffic on a small register window so renames and commits collide.
      for (int c = 0; c < 400; c++) begin
         rst  = ($urandom_range(0, 99) != 0);
         rdy  = ($urandom_range(0, 4) != 0);
         clr  = ($urandom_range(0, 15) == 0);
         Reg_write_S = $urandom_range(0, 1);
         Reg_rd      = 5'($urandom_range(0, 7));
         Reg_Reorder = $urandom_range(0, 2) != 0 ? m_tag[Reg_rd] : 4'($urandom_range(0, 15));
         Reg_result  = $urandom;
         Dispatch_S  = $urandom_range(0, 1);
         Dispatch_rd = $urandom_range(0, 3) == 0 ? Reg_rd : 5'($urandom_range(0, 7));
         Dispatch_Reorder = 4'($urandom_range(0, 15));
         rs1_addr = $urandom_range(0, 1) != 0 ? Reg_rd : 5'($urandom_range(0, 7));
         rs2_addr = 5'($urandom_range(0, 31));
         #1;
         model_read(rs1_addr, eb, et, ev);
         chk("rnd.rs1_busy", {31'd0, rs1_busy}, {31'd0, eb});
         chk("rnd.rs1_reorder", {28'd0, rs1_reorder}, {28'd0, et});
         chk("rnd.rs1_value", rs1_value, ev);
         model_read(rs2_addr, eb, et, ev);
         chk("rnd.rs2_busy", {31'd0, rs2_busy}, {31'd0, eb});
         chk("rnd.rs2_reorder", {28'd0, rs2_reorder}, {28'd0, et});
         chk("rnd.rs2_value", rs2_value, ev);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural register file with per-register rename tags.
- Receiving end of the reorder buffer's commit-write interface (Reg_write_S / Reg_rd / Reg_Reorder / Reg_result).
- Dispatch reads source operands here: either a committed value or the reorder tag of the pending producer. Dispatch also renames the destination of each new instruction.
- Flush (clr) from the reorder buffer drops all pending renames.

Parameters:
REG_NUM, 32, number of architectural registers (index width = clog2(REG_NUM) = 5)
DATA_W, 32, register data width
ROB_W, 4, reorder-tag width (16-entry reorder buffer)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low
rdy  input  1  global ready; when low, all state holds
clr  input  1  flush from reorder buffer; clears all busy bits
Reg_write_S  input  1  commit write valid
Reg_rd  input  5  commit destination register
Reg_Reorder  input  ROB_W  reorder tag of committing entry
Reg_result  input  DATA_W  commit value
Dispatch_S  input  1  rename request valid
Dispatch_rd  input  5  destination register to rename
Dispatch_Reorder  input  ROB_W  tag allocated to the new instruction
rs1_addr  input  5  source-1 index
rs1_busy  output  1  source-1 pending (value not yet committed)
rs1_reorder  output  ROB_W  producer tag when busy, else 0
rs1_value  output  DATA_W  committed value when not busy, else 0
rs2_addr / rs2_busy / rs2_reorder / rs2_value  same as rs1 for source 2

Behaviour:
- State: value[REG_NUM], busy[REG_NUM], tag[REG_NUM].
- Reset (rst==0 at posedge): all value=0, busy=0, tag=0. While rst==0, read outputs are forced to busy=0, reorder=0, value=0.
- Register 0:
  - Reads always return busy=0, value=0.
  - Commits and renames to rd==0 are ignored.
- Reads are combinational:
  - busy=busy[a], reorder=tag[a] if busy else 0, value=value[a] if not busy else 0.
  - A rename in the same cycle is NOT visible to reads. The dispatching instruction reads its sources before renaming its own rd.
- Commit (rdy && Reg_write_S && Reg_rd!=0): value[rd]<=Reg_result unconditionally. busy[rd]<=0 only if busy[rd] && tag[rd]==Reg_Reorder; otherwise the register was renamed by a younger instruction and stays busy.
- Rename (rdy && Dispatch_S && !clr && Dispatch_rd!=0): busy[rd]<=1, tag[rd]<=Dispatch_Reorder.
- Same rd in the same cycle for commit and rename: the rename wins (busy=1, new tag). The value is still written.
- clr (rdy && clr):
  - All busy<=0; tags are left as is.
  - Dispatch is ignored.
  - A commit in the same cycle is still applied to value; the reorder buffer asserts clr together with the JAL/JALR write.
- rdy==0: no state change. Reads are still driven.
- Tag wrap-around: no age comparison; only equality against the stored tag is used.

Optional Feature:
REGFILE_BYPASS_EN:
- Defined: commit-to-read forwarding in the same cycle. If Reg_write_S && Reg_rd==rsX_addr && rsX_addr!=0 && busy && tag==Reg_Reorder, the read returns busy=0, reorder=0, value=Reg_result.
- Undefined: reads reflect registered state only; the forwarded result is visible one cycle later.

Test Plan:
- Reset low for 2 cycles, then high; read x5 -> busy=0, value=0. Commit x0=0xDEAD, read x0 -> value=0, busy=0.
- Rename x3 tag 7; next cycle read x3 -> busy=1, reorder=7. Commit x3 tag 7 value 0x1234; next cycle -> busy=0, value=0x1234.
- Rename x3 tag 2, then rename x3 tag 9, then commit x3 tag 2 value 0x55 -> x3 busy=1, reorder=9. Then commit tag 9 value 0x66 -> busy=0, value=0x66.
- Same cycle: commit x4 tag 1 value 0xA and rename x4 tag 5 -> next cycle busy=1, reorder=5. After a later commit with tag 5 value 0xB -> value=0xB.
- Rename x1/x2/x7, then clr with simultaneous commit x1 (tag matching) value 0x80 and Dispatch_S x9 -> all busy=0, x1=0x80, x9 not busy.
- With REGFILE_BYPASS_EN: x6 busy tag 3, commit tag 3 value 0x77 while reading x6 -> same cycle busy=0, value=0x77. Without the macro -> busy=1 that cycle, value 0x77 the next cycle.
